// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcodes, FSM states, flag layout and float field widths for the ALU
// command sequencer.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int FLAG_ILLEGAL = 3;
  localparam int FLAG_NAN     = 2;
  localparam int FLAG_INF     = 1;
  localparam int FLAG_ZERO    = 0;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  // Logic opcodes (1xx) do not produce floats, so only the illegal bit can apply.
  function automatic logic [3:0] classify(input logic [2:0] op, input logic [31:0] w);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    logic [3:0]        fl;
    e  = w[FRAC_W +: EXP_W];
    f  = w[FRAC_W-1:0];
    fl = 4'b0000;
    if (op == OP_ILL) begin
      fl[FLAG_ILLEGAL] = 1'b1;
    end else if (!op[2]) begin
      fl[FLAG_NAN]  = (&e) && (|f);
      fl[FLAG_INF]  = (&e) && !(|f);
      fl[FLAG_ZERO] = !(|e) && !(|f);
    end
    return fl;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_cmd_fifo.sv
// Synchronous FIFO with show-ahead head output, occupancy count and
// full/empty; pointers wrap naturally because DEPTH is a power of two.
module cmd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command sequencer in front of the ALU: queues commands, issues one at a
// time, waits out the ALU latency and returns result, tag and flags.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_opcode,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic [2:0]             alu_opcode,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  input  logic [31:0]            alu_o,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [TAG_W-1:0]       res_tag,
  output logic [3:0]             res_flags,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int FW = TAG_W + 3 + 64;
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  logic [FW-1:0]    fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [TAG_W-1:0] head_tag;
  logic [2:0]       head_op;
  logic [31:0]      head_a;
  logic [31:0]      head_b;

  state_e           state_q, state_d;
  logic [LW-1:0]    lat_cnt_q, lat_cnt_d;
  logic [2:0]       alu_opcode_q, alu_opcode_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [3:0]       res_flags_q, res_flags_d;
  logic             issue;

  // No bypass: a full FIFO refuses even when the FSM pops on the same edge.
  assign cmd_ready = rst_n && !fifo_full;

  cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && cmd_ready),
    .pop   (fifo_pop),
    .wdata ({cmd_tag, cmd_opcode, cmd_a, cmd_b}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_tag, head_op, head_a, head_b} = fifo_rdata;

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    tag_d        = tag_q;
    res_data_d   = res_data_q;
    res_tag_d    = res_tag_q;
    res_flags_d  = res_flags_q;
    fifo_pop     = 1'b0;
    issue        = 1'b0;

    case (state_q)
      ST_IDLE: issue = !fifo_empty;
      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          res_data_d  = alu_o;
          res_tag_d   = tag_q;
          res_flags_d = classify(alu_opcode_q, alu_o);
          state_d     = ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          if (!fifo_empty) issue = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Illegal commands never reach the ALU; they answer straight from the pop.
    if (issue) begin
      fifo_pop = 1'b1;
      if (head_op == OP_ILL) begin
        res_data_d  = 32'd0;
        res_tag_d   = head_tag;
        res_flags_d = classify(OP_ILL, 32'd0);
        state_d     = ST_RESP;
      end else begin
        alu_opcode_d = head_op;
        alu_a_d      = head_a;
        alu_b_d      = head_b;
        tag_d        = head_tag;
        lat_cnt_d    = LW'(ALU_LAT - 1);
        state_d      = ST_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      tag_q        <= '0;
      res_data_q   <= '0;
      res_tag_q    <= '0;
      res_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      tag_q        <= tag_d;
      res_data_q   <= res_data_d;
      res_tag_q    <= res_tag_d;
      res_flags_q  <= res_flags_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign res_valid  = (state_q == ST_RESP);
  assign res_data   = res_data_q;
  assign res_tag    = res_tag_q;
  assign res_flags  = res_flags_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule
